// File: rtl/tdc_pkg.sv
// Shared constants, state encoding and read-slot helper for the TDC measurement sequencer.
package tdc_pkg;

    localparam logic [5:0] TDC_ADDR_CFG1  = 6'h00;
    localparam logic [5:0] TDC_ADDR_TIME1 = 6'h10;
    localparam logic [5:0] TDC_ADDR_CC1   = 6'h11;
    localparam logic [5:0] TDC_ADDR_TIME2 = 6'h12;
    localparam logic [7:0] TDC_CFG1_START = 8'h03;

    // Index of the last of the three result reads.
    localparam logic [1:0] RD_LAST = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CFG_WR   = 3'd1,
        CFG_WAIT = 3'd2,
        WAIT_INT = 3'd3,
        RD_ISSUE = 3'd4,
        RD_WAIT  = 3'd5,
        RESULT   = 3'd6,
        DRAIN    = 3'd7
    } tdc_state_t;

    function automatic logic [5:0] rd_addr(
        input logic [1:0] idx,
        input logic [5:0] a_time1,
        input logic [5:0] a_cc1,
        input logic [5:0] a_time2
    );
        logic [5:0] addr;
        case (idx)
            2'd0:    addr = a_time1;
            2'd1:    addr = a_cc1;
            default: addr = a_time2;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/tdc_meas_sequencer_sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/tdc_meas_sequencer.sv
// One TDC measurement per trigger: CONFIG1 start write, wait for INTB, read TIME1/CLOCK_COUNT1/TIME2, hand off.
module tdc_meas_sequencer
    import tdc_pkg::*;
#(
    parameter int unsigned       TO_W       = 20,
    parameter logic [TO_W-1:0]   TIMEOUT    = 20'd100000,
    parameter logic [7:0]        CFG1_VAL   = TDC_CFG1_START,
    parameter logic [5:0]        ADDR_CFG1  = TDC_ADDR_CFG1,
    parameter logic [5:0]        ADDR_TIME1 = TDC_ADDR_TIME1,
    parameter logic [5:0]        ADDR_CC1   = TDC_ADDR_CC1,
    parameter logic [5:0]        ADDR_TIME2 = TDC_ADDR_TIME2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tdc_ready,
    input  logic        soft_reset,
    input  logic        pause,
    input  logic        trig,
    input  logic        tdc_intb,
    output logic        spi_start,
    output logic        spi_write,
    output logic [5:0]  spi_addr,
    output logic [7:0]  spi_wdata,
    input  logic        spi_done,
    input  logic [23:0] spi_rdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_time1,
    output logic [23:0] res_cc1,
    output logic [23:0] res_time2,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_ONE;

    tdc_state_t      state_r;
    logic [1:0]      idx_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            intb_s;
    logic            abort_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_intb_sync (
        .clk (clk),
        .rst (rst),
        .d   (tdc_intb),
        .q   (intb_s)
    );

    // Losing tdc_ready mid-measurement is handled exactly like a soft reset.
    assign abort_s = soft_reset | ~tdc_ready;

    // Sequencer state, SPI request fields, result capture and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= 2'd0;
            to_cnt_r    <= {TO_W{1'b0}};
            spi_start   <= 1'b0;
            spi_write   <= 1'b0;
            spi_addr    <= 6'd0;
            spi_wdata   <= 8'd0;
            res_valid   <= 1'b0;
            res_time1   <= 24'd0;
            res_cc1     <= 24'd0;
            res_time2   <= 24'd0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            spi_start   <= 1'b0;
            timeout_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (trig && tdc_ready && !pause) begin
                        state_r   <= CFG_WR;
                        busy      <= 1'b1;
                        spi_start <= 1'b1;
                        spi_write <= 1'b1;
                        spi_addr  <= ADDR_CFG1;
                        spi_wdata <= CFG1_VAL;
                    end
                end
                // The request is already on the bus here, so an abort must still drain it.
                CFG_WR: begin
                    if (abort_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= CFG_WAIT;
                    end
                end
                CFG_WAIT: begin
                    if (abort_s) begin
                        if (spi_done) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else if (spi_done) begin
                        state_r  <= WAIT_INT;
                        to_cnt_r <= {TO_W{1'b0}};
                    end
                end
                WAIT_INT: begin
                    if (abort_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else if (!intb_s) begin
                        state_r   <= RD_ISSUE;
                        idx_r     <= 2'd0;
                        spi_start <= 1'b1;
                        spi_write <= 1'b0;
                        spi_addr  <= rd_addr(2'd0, ADDR_TIME1, ADDR_CC1, ADDR_TIME2);
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r     <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end
                RD_ISSUE: begin
                    if (abort_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (abort_s) begin
                        if (spi_done) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else if (spi_done) begin
                        case (idx_r)
                            2'd0:    res_time1 <= spi_rdata;
                            2'd1:    res_cc1   <= spi_rdata;
                            default: res_time2 <= spi_rdata;
                        endcase
                        if (idx_r == RD_LAST) begin
                            state_r   <= RESULT;
                            res_valid <= 1'b1;
                        end else begin
                            state_r   <= RD_ISSUE;
                            idx_r     <= idx_r + 2'd1;
                            spi_start <= 1'b1;
                            spi_addr  <= rd_addr(idx_r + 2'd1, ADDR_TIME1, ADDR_CC1, ADDR_TIME2);
                        end
                    end
                end
                RESULT: begin
                    if (abort_s || res_ready) begin
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (spi_done) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Scoreboard bench: SPI/TDC responder model, result/timeout monitor and randomized measurement stimulus.
module tb_tdc_meas_sequencer;

    typedef struct {
        logic       w;
        logic [5:0] a;
        logic [7:0] d;
    } trans_t;

    typedef struct {
        logic [23:0] t1;
        logic [23:0] c1;
        logic [23:0] t2;
        int          vcyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tdc_ready = 1'b0;
    logic        soft_reset = 1'b0;
    logic        pause = 1'b0;
    logic        trig = 1'b0;
    logic        tdc_intb = 1'b1;
    logic        spi_start;
    logic        spi_write;
    logic [5:0]  spi_addr;
    logic [7:0]  spi_wdata;
    logic        spi_done = 1'b0;
    logic [23:0] spi_rdata = 24'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [23:0] res_time1;
    logic [23:0] res_cc1;
    logic [23:0] res_time2;
    logic        timeout_err;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_d = 4;
    int m_l = 5;
    int intb_at = -1;
    int starts_seen = 0;
    logic [23:0] tdc_reg [64];
    trans_t exp_tr[$];
    res_t   exp_res[$];
    int     exp_to[$];

    tdc_meas_sequencer #(
        .TIMEOUT (20'd100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tdc_ready   (tdc_ready),
        .soft_reset  (soft_reset),
        .pause       (pause),
        .trig        (trig),
        .tdc_intb    (tdc_intb),
        .spi_start   (spi_start),
        .spi_write   (spi_write),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_done    (spi_done),
        .spi_rdata   (spi_rdata),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_time1   (res_time1),
        .res_cc1     (res_cc1),
        .res_time2   (res_time2),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_trig(output int tc);
        trig = 1'b1;
        tc   = cyc;
        tick(1);
        trig = 1'b0;
    endtask

    // Pushes the expected SPI traffic and result for one measurement, then triggers it.
    task automatic start_meas(input int d, input int l, input int nrd, input bit want_res, input bit want_to);
        trans_t t;
        res_t   r;
        int     tc;
        m_d = d;
        m_l = l;
        t.w = 1'b1; t.a = 6'h00; t.d = 8'h03;
        exp_tr.push_back(t);
        for (int i = 0; i < nrd; i++) begin
            t.w = 1'b0; t.a = 6'h10 + 6'(i); t.d = 8'h00;
            exp_tr.push_back(t);
        end
        pulse_trig(tc);
        if (want_res) begin
            r.t1   = tdc_reg[6'h10];
            r.c1   = tdc_reg[6'h11];
            r.t2   = tdc_reg[6'h12];
            r.vcyc = tc + 4 * d + l + 7;
            exp_res.push_back(r);
        end
        if (want_to) exp_to.push_back(tc + d + 102);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (res_valid) ok = 1'b1;
            else tick(1);
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL res_valid_wait: no result within 3000 cycles");
        end
    endtask

    task automatic run_meas(input int d, input int l, input int hold, input bit early, input bit extra);
        bit ok;
        int tc2;
        tdc_reg[6'h10] = 24'($urandom());
        tdc_reg[6'h11] = 24'($urandom());
        tdc_reg[6'h12] = 24'($urandom());
        res_ready = early;
        start_meas(d, l, 3, 1'b1, 1'b0);
        if (extra) begin
            tick(2);
            pulse_trig(tc2);
        end
        wait_valid(ok);
        if (ok) begin
            if (!early) begin
                tick(hold);
                res_ready = 1'b1;
            end
            tick(1);
            res_ready = 1'b0;
            tick(2);
            chk("busy_after_accept", busy, 1'b0);
        end
        chk("spi_txn_all_seen", exp_tr.size(), 0);
    endtask

    // SPI master / TDC model: checks each request against the expected traffic and answers after m_d cycles.
    initial begin : spi_model
        int     cnt;
        trans_t cur;
        trans_t e;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (cnt > 0) begin
                chk("spi_hold", {spi_start, spi_write, spi_addr, spi_wdata}, {1'b0, cur.w, cur.a, cur.d});
                cnt--;
                if (cnt == 0) begin
                    spi_done  = 1'b1;
                    spi_rdata = cur.w ? 24'h000000 : tdc_reg[cur.a];
                    if (cur.w && m_l >= 0) intb_at = cyc + m_l;
                end
            end else if (spi_start === 1'b1) begin
                starts_seen++;
                cur.w = spi_write;
                cur.a = spi_addr;
                cur.d = spi_wdata;
                if (exp_tr.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spi_unexpected: start w=%0b addr %0h with no request expected", spi_write, spi_addr);
                end else begin
                    e = exp_tr.pop_front();
                    chk("spi_txn", {cur.w, cur.a, e.w ? cur.d : 8'h00}, {e.w, e.a, e.d});
                end
                cnt = m_d;
                if (!cur.w) begin
                    tdc_intb = 1'b1;
                    intb_at  = -1;
                end
            end
            if (intb_at >= 0 && cyc == intb_at) tdc_intb = 1'b0;
        end
    end

    // Result and timeout monitor, sampled late in each cycle after all drivers have settled.
    initial begin : monitor
        logic        pv;
        logic        pr;
        logic        pto;
        logic [71:0] pdata;
        res_t        e;
        pv = 1'b0; pr = 1'b0; pto = 1'b0; pdata = 72'd0;
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                pv = 1'b0; pr = 1'b0; pto = 1'b0;
            end else begin
                if (pv && pr) begin
                    chk("res_valid_drop", res_valid, 1'b0);
                end else if (pv) begin
                    chk("res_valid_hold", res_valid, 1'b1);
                    chk("res_data_stable", {res_time1, res_cc1, res_time2}, pdata);
                end else if (res_valid) begin
                    if (exp_res.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL res_unexpected: res_valid with no result expected (cycle %0d)", cyc);
                    end else begin
                        e = exp_res.pop_front();
                        chk("res_time1", res_time1, e.t1);
                        chk("res_cc1", res_cc1, e.c1);
                        chk("res_time2", res_time2, e.t2);
                        chk("res_latency_cycle", cyc, e.vcyc);
                    end
                end
                if (pto) begin
                    chk("timeout_pulse_width", timeout_err, 1'b0);
                    chk("busy_after_timeout", busy, 1'b0);
                end
                if (timeout_err) begin
                    if (exp_to.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL timeout_unexpected: timeout_err with none expected (cycle %0d)", cyc);
                    end else begin
                        chk("timeout_cycle", cyc, exp_to.pop_front());
                    end
                end
                pv    = res_valid;
                pr    = res_ready;
                pto   = timeout_err;
                pdata = {res_time1, res_cc1, res_time2};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int tc;
        int base;
        bit ok;
        for (int i = 0; i < 64; i++) tdc_reg[i] = 24'd0;
        @(posedge clk);
        #1;
        tick(2);
        chk("rst_spi", {spi_start, spi_write, spi_addr, spi_wdata}, 16'd0);
        chk("rst_res", {res_valid, res_time1, res_cc1, res_time2}, 73'd0);
        chk("rst_status", {timeout_err, busy}, 2'd0);
        rst = 1'b0;
        tdc_ready = 1'b1;
        tick(3);

        // Nominal measurement with fixed data.
        tdc_reg[6'h10] = 24'h000123;
        tdc_reg[6'h11] = 24'h000045;
        tdc_reg[6'h12] = 24'h000678;
        start_meas(10, 50, 3, 1'b1, 1'b0);
        tick(1);
        chk("busy_during_meas", busy, 1'b1);
        wait_valid(ok);
        if (ok) begin
            tick(5);
            res_ready = 1'b1;
            tick(1);
            res_ready = 1'b0;
        end
        tick(2);
        chk("nominal_txn_all_seen", exp_tr.size(), 0);
        chk("nominal_busy_idle", busy, 1'b0);

        // Triggers that must be ignored.
        pause = 1'b1;
        pulse_trig(tc);
        tick(5);
        chk("pause_blocks_trig", busy, 1'b0);
        pause = 1'b0;
        tdc_ready = 1'b0;
        pulse_trig(tc);
        tick(5);
        chk("not_ready_blocks_trig", busy, 1'b0);
        tdc_ready = 1'b1;
        tick(2);
        run_meas(6, 20, 2, 1'b0, 1'b1);

        // INTB never arrives.
        start_meas(5, -1, 0, 1'b0, 1'b1);
        tick(120);
        chk("timeout_busy_idle", busy, 1'b0);
        chk("timeout_txn_all_seen", exp_tr.size(), 0);

        // Soft reset during the second read: drain, no result, then a clean run.
        tdc_reg[6'h10] = 24'h0a0b0c;
        base = starts_seen;
        start_meas(20, 10, 2, 1'b0, 1'b0);
        for (int i = 0; i < 2000 && starts_seen < base + 3; i++) tick(1);
        chk("abort_second_read_reached", starts_seen, base + 3);
        tick(3);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        chk("abort_busy_while_draining", busy, 1'b1);
        tick(30);
        chk("abort_busy_idle", busy, 1'b0);
        chk("abort_txn_all_seen", exp_tr.size(), 0);
        run_meas(3, 8, 1, 1'b0, 1'b0);

        // Long backpressure with an ignored trigger while the result waits.
        tdc_reg[6'h10] = 24'hfedcba;
        tdc_reg[6'h11] = 24'h000001;
        tdc_reg[6'h12] = 24'h800000;
        start_meas(4, 12, 3, 1'b1, 1'b0);
        wait_valid(ok);
        if (ok) begin
            tick(50);
            pulse_trig(tc);
            tick(149);
            res_ready = 1'b1;
            tick(1);
            res_ready = 1'b0;
        end
        tick(3);
        chk("backpressure_busy_idle", busy, 1'b0);

        // Randomized measurements.
        for (int k = 0; k < 8; k++) begin
            run_meas($urandom_range(1, 12), $urandom_range(1, 60), $urandom_range(0, 6),
                     1'($urandom_range(0, 1)), 1'b0);
            tick($urandom_range(0, 4));
        end

        // Synchronous reset while waiting for INTB.
        start_meas(4, -1, 0, 1'b0, 1'b0);
        tick(15);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("midrst_spi", {spi_start, spi_write, spi_addr, spi_wdata}, 16'd0);
        chk("midrst_res", {res_valid, res_time1, res_cc1, res_time2}, 73'd0);
        chk("midrst_status", {timeout_err, busy}, 2'd0);
        rst = 1'b0;
        tick(5);
        chk("midrst_stays_idle", busy, 1'b0);

        chk("final_txn_queue_empty", exp_tr.size(), 0);
        chk("final_res_queue_empty", exp_res.size(), 0);
        chk("final_timeout_queue_empty", exp_to.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_meas_sequencer.md
Name: tdc_meas_sequencer

Overview:
- Sequences one TDC measurement per trigger: SPI write to CONFIG1 (start), wait for TDC INTB, SPI-read TIME1, CLOCK_COUNT1, TIME2 (24-bit each), present result triple to UART packer via valid/ready.
- Sits between the UART command controller (supplies tdc_ready, soft_reset, pause) and the shared SPI master; sole SPI requester during a measurement.

Parameters:
- TO_W, 20, width of INTB timeout counter.
- TIMEOUT, 20'd100000, cycles to wait for INTB low before abort (~2 ms at 50 MHz).
- CFG1_VAL, 8'h03, CONFIG1 value written to start measurement.
- ADDR_CFG1 / ADDR_TIME1 / ADDR_CC1 / ADDR_TIME2, 6'h00 / 6'h10 / 6'h11 / 6'h12, TDC register addresses.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tdc_ready  in  1  high once TDC enable/boot sequence done
- soft_reset  in  1  1-cycle abort request
- pause  in  1  level; high blocks new triggers
- trig  in  1  1-cycle measurement request
- tdc_intb  in  1  TDC interrupt, active-low, asynchronous
- spi_start  out  1  1-cycle transaction request
- spi_write  out  1  1 = write 1 byte, 0 = read 3 bytes
- spi_addr  out  6  register address
- spi_wdata  out  8  write data
- spi_done  in  1  1-cycle completion pulse
- spi_rdata  in  24  read data, valid with spi_done
- res_valid  out  1  result triple valid
- res_ready  in  1  consumer accepts result
- res_time1 / res_cc1 / res_time2  out  24 each  captured results
- timeout_err  out  1  1-cycle pulse on INTB timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; result regs 0; INTB sync flops 1; timeout counter 0.
- tdc_intb: 2-flop synchronizer; all FSM decisions use the synchronized value (2-cycle latency).
- IDLE: trig && tdc_ready && !pause -> CFG_WR. trig otherwise ignored (no queuing). trig while busy ignored.
- CFG_WR: spi_start=1 one cycle, spi_write=1, addr=ADDR_CFG1, wdata=CFG1_VAL -> CFG_WAIT.
- CFG_WAIT: on spi_done -> WAIT_INT, clear timeout counter.
- WAIT_INT: synced INTB==0 -> RD_ISSUE with index 0. Else counter++; counter==TIMEOUT-1 -> timeout_err pulse, -> IDLE (no result).
- RD_ISSUE: spi_start=1 one cycle, spi_write=0, addr by index (0:TIME1, 1:CC1, 2:TIME2) -> RD_WAIT.
- RD_WAIT: on spi_done capture spi_rdata into register for index; index<2 -> index+1, RD_ISSUE; index==2 -> RESULT.
- RESULT: res_valid=1, data stable; res_ready -> res_valid=0 next cycle, -> IDLE. res_ready may already be high on entry (accept in first cycle).
- spi_start never asserted while a transaction is outstanding; spi_addr/spi_write/spi_wdata held stable from spi_start until spi_done.
- soft_reset: in CFG_WAIT/RD_WAIT -> DRAIN (wait for spi_done, discard data, -> IDLE); in any other state -> IDLE next cycle, res_valid cleared. soft_reset in IDLE: no effect. soft_reset wins over simultaneous trig/spi_done/INTB.
- pause only gates new triggers; in-flight measurement completes.
- tdc_ready falling mid-measurement: treated as soft_reset.
- Measurement latency (trig to res_valid) = 2 + CFG SPI time + INTB latency + 3 read SPI times + 3 cycles of FSM overhead; verify exact count against the SPI model.

Decomposition:
- Shared package tdc_pkg: register address constants, CONFIG1 start value, state encoding localparams (IDLE, CFG_WR, CFG_WAIT, WAIT_INT, RD_ISSUE, RD_WAIT, RESULT, DRAIN).
- One sub-module: sync_2ff (generic 2-flop synchronizer, reset value parameter) for tdc_intb.

Test Plan:
- Nominal: tdc_ready=1, trig; SPI model done after 10 cycles returning 24'h000123, 24'h000045, 24'h000678; INTB low 50 cycles after CFG write -> exactly 1 write (addr 0x00, data 0x03), 3 reads (addr 0x10, 0x11, 0x12), res_valid with those values until res_ready.
- Timeout: TIMEOUT=100, INTB held high -> timeout_err pulses once 100 cycles after WAIT_INT entry, no read issued, busy low next cycle.
- Gating: trig with pause=1, then trig with tdc_ready=0, then trig while busy -> no spi_start for any of them.
- Abort mid-read: soft_reset during second RD_WAIT -> no new spi_start, FSM waits for spi_done, returns IDLE; res_valid never asserted; next trig runs a clean measurement.
- Backpressure: res_ready held low 200 cycles -> res_valid and data stable; trig during RESULT ignored; res_ready=1 -> res_valid drops next cycle.
- Reset mid-measurement: rst in WAIT_INT -> all outputs 0 the following cycle, state IDLE.
